// File: rtl/adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_arbiter_pkg
//   Shared constants for the adder arbiter slice. WORD is the datapath width,
//   CYCLE the nominal clock period in time units, and ADDARB_NUM_REQ the default
//   number of requesters (PC-increment, branch-target, address-generation, ...).
// -----------------------------------------------------------------------------
package adder_arbiter_pkg;

  localparam int unsigned WORD           = 64;
  localparam int unsigned CYCLE          = 10;
  localparam int unsigned ADDARB_NUM_REQ = 4;

  // Next round-robin candidate after 'cur', wrapping modulo 'n'.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned step,
                                          input int unsigned n);
    return (cur + step) % n;
  endfunction

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
//   Shared combinational WORD-bit adder. Carry out is discarded, so the result
//   wraps modulo 2^WORD.
//
//   a_in    in  WORD : operand A
//   b_in    in  WORD : operand B
//   add_out out WORD : a_in + b_in (mod 2^WORD)
// -----------------------------------------------------------------------------
module adder
  import adder_arbiter_pkg::*;
(
  input  logic [WORD-1:0] a_in,
  input  logic [WORD-1:0] b_in,
  output logic [WORD-1:0] add_out
);

  assign add_out = a_in + b_in;

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. The search starts one past
//   last_grant and wraps; the first requesting index wins. The pointer register
//   itself is owned by the instantiating module.
//
//   req        in  NUM_REQ : request vector
//   last_grant in  ID_W    : index granted most recently
//   enable     in  1       : when low, no grant is issued
//   grant      out NUM_REQ : one-hot grant or zero
//   grant_id   out ID_W    : index of the granted requester (0 when none)
//   any        out 1       : a grant is issued
// -----------------------------------------------------------------------------
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = ADDARB_NUM_REQ,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    if (enable) begin
      // Offsets 1..NUM_REQ visit every requester once, ending on last_grant itself.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = ID_W'(rr_next(32'(last_grant), k, NUM_REQ));
        if (!any && req[idx]) begin
          grant[idx] = 1'b1;
          grant_id   = idx;
          any        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Shares one combinational adder between NUM_REQ requesters. Each cycle at
//   most one request is granted (round-robin); its operands drive the adder and
//   the sum is captured, tagged with the requester ID, in a one-entry response
//   register. A response can be consumed and replaced in the same cycle, giving
//   one result per cycle under full load.
//
//   clk        in  1             : clock, rising edge
//   reset      in  1             : asynchronous active-high reset
//   req_valid  in  NUM_REQ       : requester i has operands pending
//   req_a_in   in  NUM_REQ*WORD  : packed operand A, slice i for requester i
//   req_b_in   in  NUM_REQ*WORD  : packed operand B, slice i for requester i
//   req_ready  out NUM_REQ       : one-hot accept (or zero), combinational
//   resp_valid out 1             : response register holds a result
//   resp_id    out ID_W          : owner of the result
//   resp_sum   out WORD          : a + b (mod 2^WORD)
//   resp_ready in  1             : consumer takes the response this cycle
// -----------------------------------------------------------------------------
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = ADDARB_NUM_REQ,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*WORD-1:0] req_a_in,
  input  logic [NUM_REQ*WORD-1:0] req_b_in,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [WORD-1:0]         resp_sum,
  input  logic                    resp_ready
);

  logic                    resp_valid_q;
  logic [ID_W-1:0]         resp_id_q;
  logic [WORD-1:0]         resp_sum_q;
  logic [ID_W-1:0]         last_grant_q;

  logic                    can_accept;
  logic                    arb_enable;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_id;
  logic                    any_grant;

  logic [WORD-1:0]         a_arr [NUM_REQ];
  logic [WORD-1:0]         b_arr [NUM_REQ];
  logic [WORD-1:0]         add_a;
  logic [WORD-1:0]         add_b;
  logic [WORD-1:0]         add_out;

  // Free slot now, or the current occupant leaves at this edge.
  assign can_accept = !resp_valid_q || resp_ready;
  // Keep req_ready low for the whole reset window, not just after the edge.
  assign arb_enable = can_accept && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_enable),
    .grant      (grant),
    .grant_id   (grant_id),
    .any        (any_grant)
  );

  assign req_ready = grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_in[g*WORD +: WORD];
    assign b_arr[g] = req_b_in[g*WORD +: WORD];
  end

  // One-hot operand mux; idle adder sees zeros so it does not toggle on stale data.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        add_a = a_arr[i];
        add_b = b_arr[i];
      end
    end
  end

  adder u_adder (
    .a_in    (add_a),
    .b_in    (add_b),
    .add_out (add_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else if (any_grant) begin
      // Covers both a fresh load and consume-plus-reload in the same cycle.
      resp_valid_q <= 1'b1;
      resp_id_q    <= grant_id;
      resp_sum_q   <= add_out;
      last_grant_q <= grant_id;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

  a_stall_no_grant: assert property (@(posedge clk) disable iff (reset)
    (resp_valid && !resp_ready) |-> (req_ready == '0));

  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_sum) && $stable(resp_id)));

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*WORD-1:0] req_a_in;
  logic [NR*WORD-1:0] req_b_in;
  logic [NR-1:0]    req_ready;
  logic             resp_valid;
  logic [1:0]       resp_id;
  logic [WORD-1:0]  resp_sum;
  logic             resp_ready;

  adder_arbiter #(
    .NUM_REQ (NR),
    .ID_W    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a_in   (req_a_in),
    .req_b_in   (req_b_in),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_ready (resp_ready)
  );

  always #(CYCLE / 2) clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int              id;
    logic [WORD-1:0] sum;
  } sb_t;

  sb_t             sb_q[$];
  int              grant_log[$];
  logic [WORD-1:0] resp_log[$];

  // Reference round-robin choice: first valid index after 'last', wrapping.
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model and scoreboard, sampled late in each cycle.
  int          m_last  = NR - 1;
  logic        m_valid = 1'b0;
  int          m_pick;
  logic [NR-1:0] m_ready;
  sb_t         m_e;

  always @(posedge clk) begin
    #8;
    if (reset) begin
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      sb_q.delete();
      m_last  = NR - 1;
      m_valid = 1'b0;
    end else begin
      check("resp_valid", 64'(resp_valid), 64'(m_valid));
      if (m_valid && resp_ready) begin
        check("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
          m_e = sb_q.pop_front();
          check("resp_id", 64'(resp_id), 64'(m_e.id));
          check("resp_sum", resp_sum, m_e.sum);
          resp_log.push_back(resp_sum);
        end
      end
      m_pick  = (!m_valid || resp_ready) ? rr_pick(req_valid, m_last) : -1;
      m_ready = (m_pick >= 0) ? NR'(1 << m_pick) : '0;
      check("req_ready", 64'(req_ready), 64'(m_ready));
      if (m_pick >= 0) begin
        m_e.id  = m_pick;
        m_e.sum = req_a_in[m_pick*WORD +: WORD] + req_b_in[m_pick*WORD +: WORD];
        sb_q.push_back(m_e);
        grant_log.push_back(m_pick);
        m_last  = m_pick;
        m_valid = 1'b1;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WORD-1:0] a, input logic [WORD-1:0] b);
    req_a_in[i*WORD +: WORD] = a;
    req_b_in[i*WORD +: WORD] = b;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #(CYCLE * 20000);
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int exp_grants[5] = '{0, 1, 2, 3, 0};
  logic [WORD-1:0] exp_sums[5] = '{100, 101, 102, 103, 100};

  initial begin
    reset      = 1'b1;
    req_valid  = '1;
    req_a_in   = '0;
    req_b_in   = '0;
    resp_ready = 1'b1;

    // Reset state, with requests present that must not be granted.
    repeat (2) step();
    #6;
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_resp_valid", 64'(resp_valid), 64'(0));
    check("reset_resp_id", 64'(resp_id), 64'(0));
    check("reset_resp_sum", resp_sum, 64'(0));

    // Single requester right after reset release.
    step();
    reset     = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 5, 55);
    #6;
    check("t1_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    #6;
    check("t1_valid", 64'(resp_valid), 64'(1));
    check("t1_id", 64'(resp_id), 64'(0));
    check("t1_sum", resp_sum, 64'(60));
    step();
    #6;
    check("t1_drop", 64'(resp_valid), 64'(0));

    // All four continuously valid: rotation and one result per cycle.
    do_reset();
    grant_log.delete();
    resp_log.delete();
    for (int i = 0; i < NR; i++) set_op(i, WORD'(i), 100);
    req_valid = 4'b1111;
    repeat (4) step();
    step();
    req_valid = '0;
    step();
    step();
    check("t2_grant_count", 64'(grant_log.size()), 64'(5));
    check("t2_resp_count", 64'(resp_log.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("t2_grant_order", 64'(grant_log[i]), 64'(exp_grants[i]));
      if (i < resp_log.size()) check("t2_sum_order", resp_log[i], exp_sums[i]);
    end

    // Backpressure with requesters 1 and 2 valid (last grant was 0).
    set_op(1, 10, 1);
    set_op(2, 20, 2);
    step();
    req_valid = 4'b0110;
    #6;
    check("t3_first_grant", 64'(req_ready), 64'b0010);
    step();
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #6;
      check("t3_stall_ready", 64'(req_ready), 64'(0));
      check("t3_stall_id", 64'(resp_id), 64'(1));
      check("t3_stall_sum", resp_sum, 64'(11));
      if (c < 2) step();
    end
    step();
    resp_ready = 1'b1;
    #6;
    check("t3_release_grant", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    #6;
    check("t3_new_id", 64'(resp_id), 64'(2));
    check("t3_new_sum", resp_sum, 64'(22));
    step();

    // Wrap-around arithmetic.
    set_op(3, '1, 1);
    req_valid = 4'b1000;
    #6;
    check("t4_ready3", 64'(req_ready), 64'b1000);
    step();
    set_op(0, 59000, 24);
    req_valid = 4'b0001;
    #6;
    check("t4_wrap_id", 64'(resp_id), 64'(3));
    check("t4_wrap_sum", resp_sum, 64'(0));
    check("t4_ready0", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    #6;
    check("t4_sum", resp_sum, 64'(59024));
    step();

    // Reset half a cycle after an accept of requester 3.
    set_op(3, 7, 8);
    req_valid = 4'b1000;
    #6;
    check("t5_ready3", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    #1;
    check("t5_pre_valid", 64'(resp_valid), 64'(1));
    check("t5_pre_id", 64'(resp_id), 64'(3));
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_valid", 64'(resp_valid), 64'(0));
    check("t5_async_ready", 64'(req_ready), 64'(0));
    step();
    step();
    reset     = 1'b0;
    req_valid = 4'b1001;
    #6;
    check("t5_first_after_reset", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    step();

    // Sparse alternating requests, then idle cycles, then all valid.
    for (int c = 0; c < 6; c++) begin
      req_valid = (c % 2 == 0) ? 4'b1000 : 4'b0010;
      #6;
      check("t6_sparse_grant", 64'(req_ready), 64'(req_valid));
      step();
    end
    req_valid = '0;
    step();
    step();
    req_valid = 4'b1111;
    #6;
    check("t6_ptr_held", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    step();
    step();

    check("final_sb_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
